ps2_key_tracker: RTL and testbench

- Receives raw PS/2 keyboard traffic and keeps a live held/released bitmap of the six game keys.
- Sits directly upstream of the VGA sprite/game FSM, which consumes key_status once per frame.
- Contains a clock-line filter, a bit-serial frame receiver FSM, and a scan-code decoder that handles F0 (break) and E0 (extended) prefixes.

---
 rtl/ps2_key_tracker.sv | 177 +++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver that maintains a held/released bitmap of six game keys.
// Pipeline: 2-FF synchronizers, ps2_clk glitch filter, frame FSM, then the scan-code decoder.
module ps2_key_tracker #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] key_status,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_c, sdata_c;
  logic [1:0]    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [5:0]    key_q, key_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [5:0]    mask_c;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = ~filt_q;
      else                               fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign fall_c  = filt_q & ~filt_d;
  assign sdata_c = data_sync_q[1];

  // Game-key lookup on the received byte, qualified by the E0 prefix.
  always_comb begin
    mask_c = '0;
    case ({ext_q, shift_q})
      9'h01D:  mask_c = 6'b000001;
      9'h01C:  mask_c = 6'b000010;
      9'h01B:  mask_c = 6'b000100;
      9'h023:  mask_c = 6'b001000;
      9'h029:  mask_c = 6'b010000;
      9'h076:  mask_c = 6'b100000;
      9'h175:  mask_c = 6'b000001;
      9'h16B:  mask_c = 6'b000010;
      9'h172:  mask_c = 6'b000100;
      9'h174:  mask_c = 6'b001000;
      default: mask_c = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q;
    brk_d   = brk_q;
    ext_d   = ext_q;
    key_d   = key_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (fall_c && !sdata_c) begin
          state_d = S_DATA;
          bcnt_d  = '0;
        end
      end
      default: begin
        tcnt_d = tcnt_q + TW'(1);
        if (fall_c) begin
          tcnt_d = '0;
          case (state_q)
            S_DATA: begin
              shift_d = {sdata_c, shift_q[7:1]};
              bcnt_d  = bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
              par_d   = sdata_c;
              state_d = S_STOP;
            end
            default: begin
              state_d = S_IDLE;
              if (sdata_c && (^{shift_q, par_q})) begin
                code_d  = shift_q;
                valid_d = 1'b1;
                if (shift_q == 8'hE0)      ext_d = 1'b1;
                else if (shift_q == 8'hF0) brk_d = 1'b1;
                else begin
                  key_d = brk_q ? (key_q & ~mask_c) : (key_q | mask_c);
                  brk_d = 1'b0;
                  ext_d = 1'b0;
                end
              end else begin
                err_d = 1'b1;
                brk_d = 1'b0;
                ext_d = 1'b0;
              end
            end
          endcase
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          // Line went quiet mid-frame: drop the partial byte and any pending prefix.
          state_d = S_IDLE;
          tcnt_d  = '0;
          err_d   = 1'b1;
          brk_d   = 1'b0;
          ext_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      fcnt_q      <= '0;
      state_q     <= S_IDLE;
      bcnt_q      <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_q       <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tcnt_q      <= tcnt_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_q       <= key_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign key_status = key_q;
  assign scan_code  = code_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: bit-banged PS/2 frames with hand-computed key bitmaps.
module tb_ps2_key_tracker;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [5:0] key_status;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  int n_checks = 0;
  int n_fail = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int wide_pulse = 0;
  int stray_key = 0;
  logic cv_prev = 1'b0, fe_prev = 1'b0, rst_prev = 1'b1;
  logic [5:0] key_prev = '0;
  int cv0, fe0;

  ps2_key_tracker #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_status(key_status), .scan_code(scan_code),
    .code_valid(code_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counting plus watch for over-long pulses and key changes outside code_valid.
  always @(negedge clk) begin
    if (code_valid) cv_cnt++;
    if (frame_err) fe_cnt++;
    if ((code_valid && cv_prev) || (frame_err && fe_prev)) wide_pulse++;
    if (!reset && !rst_prev && key_status !== key_prev && !code_valid) stray_key++;
    cv_prev  = code_valid;
    fe_prev  = frame_err;
    rst_prev = reset;
    key_prev = key_status;
  end

  task automatic send_bit(input logic v, input bit glitch);
    @(negedge clk);
    ps2_data = v;
    if (glitch) begin
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk);
    end else repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (glitch) begin
      repeat (4) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (16) @(negedge clk);
    end else repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch && (i % 3 == 1));
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (key_status !== 6'b0) begin n_fail++; $display("FAIL reset_key: got %b want %b", key_status, 6'b0); end
    n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_code: got %h want 00", scan_code); end
    n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", code_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", frame_err); end
  endtask

  task automatic test_make_break;
    cv0 = cv_cnt;
    send(8'h1D);
    n_checks++; if (scan_code !== 8'h1D) begin n_fail++; $display("FAIL w_make_code: got %h want 1d", scan_code); end
    n_checks++; if (key_status !== 6'b000001) begin n_fail++; $display("FAIL w_make_key: got %b want 000001", key_status); end
    n_checks++; if (cv_cnt - cv0 !== 1) begin n_fail++; $display("FAIL w_make_valid: got %0d want 1", cv_cnt - cv0); end
    send(8'hF0);
    n_checks++; if (key_status !== 6'b000001) begin n_fail++; $display("FAIL f0_hold_key: got %b want 000001", key_status); end
    send(8'h1D);
    n_checks++; if (key_status !== 6'b000000) begin n_fail++; $display("FAIL w_break_key: got %b want 000000", key_status); end
    n_checks++; if (cv_cnt - cv0 !== 3) begin n_fail++; $display("FAIL w_break_valid: got %0d want 3", cv_cnt - cv0); end
  endtask

  task automatic test_alias;
    send(8'hE0);
    send(8'h74);
    n_checks++; if (key_status !== 6'b001000) begin n_fail++; $display("FAIL right_make: got %b want 001000", key_status); end
    send(8'h23);
    n_checks++; if (key_status !== 6'b001000) begin n_fail++; $display("FAIL d_make: got %b want 001000", key_status); end
    send(8'hF0);
    send(8'h23);
    n_checks++; if (key_status !== 6'b000000) begin n_fail++; $display("FAIL d_break: got %b want 000000", key_status); end
    n_checks++; if (scan_code !== 8'h23) begin n_fail++; $display("FAIL d_break_code: got %h want 23", scan_code); end
  endtask

  task automatic test_frame_errors;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h29, 1'b1, 1'b0, 1'b0, 11);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL parity_err: got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (cv_cnt - cv0 !== 0) begin n_fail++; $display("FAIL parity_valid: got %0d want 0", cv_cnt - cv0); end
    n_checks++; if (scan_code !== 8'h23) begin n_fail++; $display("FAIL parity_code: got %h want 23", scan_code); end
    n_checks++; if (key_status !== 6'b000000) begin n_fail++; $display("FAIL parity_key: got %b want 000000", key_status); end
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11);
    n_checks++; if (fe_cnt - fe0 !== 2) begin n_fail++; $display("FAIL stop_err: got %0d want 2", fe_cnt - fe0); end
    n_checks++; if (key_status !== 6'b000000) begin n_fail++; $display("FAIL stop_key: got %b want 000000", key_status); end
  endtask

  task automatic test_timeout;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h76, 1'b0, 1'b0, 1'b0, 5);
    repeat (TMO + 10) @(negedge clk);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_err: got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (cv_cnt - cv0 !== 0) begin n_fail++; $display("FAIL timeout_valid: got %0d want 0", cv_cnt - cv0); end
    send(8'h76);
    n_checks++; if (key_status !== 6'b100000) begin n_fail++; $display("FAIL esc_make: got %b want 100000", key_status); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL after_timeout_err: got %0d want 1", fe_cnt - fe0); end
  endtask

  task automatic test_glitch;
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 11);
    n_checks++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL glitch_code: got %h want 1c", scan_code); end
    n_checks++; if (key_status !== 6'b100010) begin n_fail++; $display("FAIL glitch_key: got %b want 100010", key_status); end
    n_checks++; if (cv_cnt - cv0 !== 1 || fe_cnt - fe0 !== 0) begin
      n_fail++; $display("FAIL glitch_pulses: got valid=%0d err=%0d want 1/0", cv_cnt - cv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_keypad_and_repeat;
    cv0 = cv_cnt;
    send(8'h75);
    n_checks++; if (key_status !== 6'b100010) begin n_fail++; $display("FAIL keypad_ignored: got %b want 100010", key_status); end
    n_checks++; if (scan_code !== 8'h75) begin n_fail++; $display("FAIL keypad_code: got %h want 75", scan_code); end
    send(8'hE0); send(8'h72);
    n_checks++; if (key_status !== 6'b100110) begin n_fail++; $display("FAIL down_make: got %b want 100110", key_status); end
    send(8'hE0); send(8'hF0); send(8'h72);
    n_checks++; if (key_status !== 6'b100010) begin n_fail++; $display("FAIL down_break: got %b want 100010", key_status); end
    send(8'h1D); send(8'h1D);
    n_checks++; if (key_status !== 6'b100011) begin n_fail++; $display("FAIL typematic: got %b want 100011", key_status); end
    n_checks++; if (cv_cnt - cv0 !== 8) begin n_fail++; $display("FAIL keypad_valid: got %0d want 8", cv_cnt - cv0); end
  endtask

  task automatic test_reset_midframe;
    send(8'hE0);
    send(8'hF0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (key_status !== 6'b000000) begin n_fail++; $display("FAIL midreset_key: got %b want 000000", key_status); end
    n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL midreset_code: got %h want 00", scan_code); end
    n_checks++; if (code_valid !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL midreset_pulses: got valid=%b err=%b want 0/0", code_valid, frame_err);
    end
    send(8'h1B);
    n_checks++; if (key_status !== 6'b000100) begin n_fail++; $display("FAIL s_after_reset: got %b want 000100", key_status); end
    n_checks++; if (scan_code !== 8'h1B) begin n_fail++; $display("FAIL s_after_reset_code: got %h want 1b", scan_code); end
  endtask

  task automatic test_pulse_shape;
    n_checks++; if (wide_pulse !== 0) begin n_fail++; $display("FAIL pulse_width: got %0d long pulses want 0", wide_pulse); end
    n_checks++; if (stray_key !== 0) begin n_fail++; $display("FAIL key_latency: got %0d unaligned updates want 0", stray_key); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_alias();
    test_frame_errors();
    test_timeout();
    test_glitch();
    test_keypad_and_repeat();
    test_reset_midframe();
    test_pulse_shape();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
